scene_renderer: RTL and testbench
=================================

SCENE_RENDERER -- requirements
Module: scene_renderer

Interface
REQ-001 Parameter NUM_SCENES, default 4: number of background images stored back-to-back in the external ROM.
REQ-002 Parameter IMG_W, default 256: image width in pixels; SHALL be a power of two.
REQ-003 Parameter IMG_H, default 240: image height in pixels.
REQ-004 Parameter SCALE_SHIFT, default 1: screen-to-image downscale, image coordinate = screen coordinate >> SCALE_SHIFT.
REQ-005 Parameter ROM_AW, default $clog2(NUM_SCENES*IMG_W*IMG_H): ROM address width.
REQ-006 vga_clk  in  1  sole clock; one clock, all logic on posedge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 draw_x, draw_y  in  10 each  current screen pixel coordinate.
REQ-009 blank  in  1  high = visible pixel, low = blanking interval.
REQ-010 frame_start  in  1  one-cycle pulse at the start of each frame.
REQ-011 scroll_x  in  $clog2(IMG_W)  horizontal scroll offset in image pixels.
REQ-012 scene_sel  in  $clog2(NUM_SCENES)  target scene index.
REQ-013 scene_req  in  1  one-cycle pulse requesting a fade transition to scene_sel.
REQ-014 rom_addr  out  ROM_AW  address to the external synchronous ROM.
REQ-015 rom_q  in  4  palette index returned one cycle after rom_addr.
REQ-016 busy  out  1  high while a fade transition is in progress.
REQ-017 red, green, blue  out  4 each  registered pixel colour.

Function
REQ-018 At each frame_start, scroll_x SHALL be latched into scroll_lat; mid-frame changes to scroll_x SHALL have no effect until the next frame_start.
REQ-019 Stage 1 SHALL register rom_addr = active_scene*IMG_W*IMG_H + iy*IMG_W + ix, where ix = ((draw_x>>SCALE_SHIFT)+scroll_lat) mod IMG_W and iy = draw_y>>SCALE_SHIFT.
REQ-020 Horizontal wrap: ix SHALL wrap modulo IMG_W, with no gap or repeated column at the seam.
REQ-021 If iy >= IMG_H, the pixel SHALL be flagged out-of-image, rom_addr SHALL be driven to the scene base, and the output SHALL be black.
REQ-022 blank and the out-of-image flag SHALL be delayed alongside the data so that all three stay aligned.
REQ-023 Latency: inputs sampled at cycle N SHALL produce red/green/blue at cycle N+3 (stage 1 address, stage 2 ROM, stage 3 palette + fade into the output register).
REQ-024 Output SHALL be 0/0/0 when the delayed blank is low or the pixel is out-of-image; otherwise each channel = (palette_channel * level) >> 4, where level is 5 bits in the range 0..16.
REQ-025 Fade FSM states and transitions:
- IDLE (level 16): scene_req -> FADE_OUT, with pending_scene <= scene_sel.
- FADE_OUT: level decrements by 2 on each frame_start; when level reaches 0, active_scene <= pending_scene -> FADE_IN.
- FADE_IN: level increments by 2 on each frame_start; when level reaches 16 -> IDLE.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 A scene_req while busy SHALL be ignored.
REQ-028 A scene_req equal to active_scene SHALL still perform the full fade.
REQ-029 If scene_req and frame_start arrive in the same cycle, the request SHALL be accepted and the first level step SHALL occur at the next frame_start.
REQ-030 active_scene SHALL change only in the frame_start cycle where level reaches 0, so no frame ever mixes two scenes.
REQ-031 scene_sel >= NUM_SCENES SHALL be clamped to NUM_SCENES-1.

Reset
REQ-032 On reset, the following SHALL take these values:
- red/green/blue = 0, rom_addr = 0, busy = 0.
- state = IDLE, level = 16.
- active_scene = 0, pending_scene = 0, scroll_lat = 0.
- pipeline blank/flag registers = 0.
REQ-033 Reset asserted mid-fade SHALL abort the fade; the first pixel after reset SHALL use scene 0 at full brightness.

Structure
REQ-034 A shared package scene_pkg SHALL hold fade_state_t (IDLE, FADE_OUT, FADE_IN), FADE_STEP = 2 and LEVEL_MAX = 16.
REQ-035 The palette SHALL be a combinational sub-module scene_palette_lut (4-bit index -> 12-bit RGB), instantiated once.
REQ-036 The ROM SHALL remain external to this block.

Verification
REQ-037 Latency: reset, blank = 1, draw_x = 10, draw_y = 4, scroll 0 -> rom_addr = 2*256+5 = 517 one cycle later; RGB = palette(rom_q) at N+3.
REQ-038 Wrap: scroll_x = 250 latched, draw_x = 20 -> ix = 4, rom_addr = iy*256+4; scroll_x changed mid-frame -> address unchanged until the next frame_start.
REQ-039 Out-of-image: draw_y = 480 (iy = 240) -> RGB = 0 at N+3; blank = 0 -> RGB = 0.
REQ-040 Fade: scene_req with scene_sel = 2 ->
- busy = 1.
- level 14, 12, ... 0 over 8 frame_starts; scene 2 is first used in the following frame.
- level reaches 16 after 8 more frame_starts, then busy = 0.
- palette value 0xF at level 8 -> channel 7.
REQ-041 Collisions: scene_req during FADE_IN -> ignored; scene_req coincident with frame_start -> level still 16 after that cycle.
REQ-042 Reset mid-FADE_OUT at level 6 -> busy = 0, level 16, active_scene = 0 on the next cycle.

Source files
------------

// File: rtl/scene_pkg.sv
// Shared definitions for the scene renderer.
//   fade_state_t : fade FSM encoding (IDLE, FADE_OUT, FADE_IN)
//   FADE_STEP    : brightness step applied on each frame_start while fading
//   LEVEL_MAX    : full brightness level (levels run 0..LEVEL_MAX)
//   fade_ch()    : scales one 4-bit colour channel by a 5-bit level
package scene_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_t;

    localparam int FADE_STEP = 2;
    localparam int LEVEL_MAX = 16;
    localparam int LEVEL_W   = 5;

    // (c * lvl) >> 4. The product never exceeds 15*16 = 240, so 8 bits hold it.
    function automatic logic [3:0] fade_ch(input logic [3:0] c, input logic [LEVEL_W-1:0] lvl);
        logic [7:0] p;
        p = {4'd0, c} * {3'd0, lvl};
        return p[7:4];
    endfunction

endpackage

// File: rtl/scene_palette_lut.sv
// Combinational palette: 4-bit palette index to 12-bit {R,G,B} colour.
//   idx_i : palette index (from the background ROM)
//   rgb_o : {red[3:0], green[3:0], blue[3:0]}
module scene_palette_lut (
    input  logic [3:0]  idx_i,
    output logic [11:0] rgb_o
);

    always_comb begin
        rgb_o = 12'h000;
        case (idx_i)
            4'h0: rgb_o = 12'h0F5;
            4'h1: rgb_o = 12'h1E4;
            4'h2: rgb_o = 12'h2D7;
            4'h3: rgb_o = 12'h3C6;
            4'h4: rgb_o = 12'h4B1;
            4'h5: rgb_o = 12'h5A0;
            4'h6: rgb_o = 12'h693;
            4'h7: rgb_o = 12'h782;
            4'h8: rgb_o = 12'h87D;
            4'h9: rgb_o = 12'h96C;
            4'hA: rgb_o = 12'hA5F;
            4'hB: rgb_o = 12'hB4E;
            4'hC: rgb_o = 12'hC39;
            4'hD: rgb_o = 12'hD28;
            4'hE: rgb_o = 12'hE1B;
            4'hF: rgb_o = 12'hF0A;
            default: rgb_o = 12'h000;
        endcase
    end

endmodule

// File: rtl/scene_renderer.sv
// Scrolling background renderer with frame-synchronous fade between scenes.
// Three-stage pixel pipeline: stage 1 registers the ROM address, the external
// synchronous ROM supplies the palette index in stage 2, and stage 3 applies
// palette + fade level into the registered RGB outputs.
//   vga_clk, reset        : clock, synchronous active-high reset
//   draw_x, draw_y, blank : current screen pixel, blank high = visible
//   frame_start           : one-cycle pulse per frame
//   scroll_x              : horizontal scroll in image pixels (latched per frame)
//   scene_sel, scene_req  : fade request to a new scene
//   rom_addr / rom_q      : external ROM port (1-cycle read latency)
//   busy                  : fade in progress
//   red, green, blue      : registered pixel colour
module scene_renderer
    import scene_pkg::*;
#(
    parameter int NUM_SCENES  = 4,
    parameter int IMG_W       = 256,
    parameter int IMG_H       = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int ROM_AW      = $clog2(NUM_SCENES*IMG_W*IMG_H)
) (
    input  logic                          vga_clk,
    input  logic                          reset,
    input  logic [9:0]                    draw_x,
    input  logic [9:0]                    draw_y,
    input  logic                          blank,
    input  logic                          frame_start,
    input  logic [$clog2(IMG_W)-1:0]      scroll_x,
    input  logic [$clog2(NUM_SCENES)-1:0] scene_sel,
    input  logic                          scene_req,
    output logic [ROM_AW-1:0]             rom_addr,
    input  logic [3:0]                    rom_q,
    output logic                          busy,
    output logic [3:0]                    red,
    output logic [3:0]                    green,
    output logic [3:0]                    blue
);

    localparam int XW      = $clog2(IMG_W);
    localparam int SW      = $clog2(NUM_SCENES);
    localparam int IMG_PIX = IMG_W * IMG_H;

    // Fade control state
    fade_state_t        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [SW-1:0]      active_q, active_d;
    logic [SW-1:0]      pending_q, pending_d;
    logic [SW-1:0]      sel_clamped;
    logic [XW-1:0]      scroll_lat_q;

    // Pixel pipeline
    logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
    logic [1:0]         vld_pipe_q;   // blank delayed to stage 1 / stage 2
    logic [1:0]         oob_pipe_q;   // out-of-image flag, same alignment
    logic [XW-1:0]      ix;
    logic [9:0]         iy;
    logic               oob;
    logic [ROM_AW-1:0]  scene_base;
    logic [11:0]        pal_rgb;
    logic [3:0]         red_q, green_q, blue_q;
    logic [3:0]         red_d, green_d, blue_d;

    // ---------------- stage 1: address generation ----------------
    // Truncating to XW bits gives the modulo-IMG_W wrap for free (IMG_W is 2^n).
    assign ix  = XW'(draw_x >> SCALE_SHIFT) + scroll_lat_q;
    assign iy  = draw_y >> SCALE_SHIFT;
    assign oob = (int'(iy) >= IMG_H);

    assign scene_base = ROM_AW'(active_q) * ROM_AW'(IMG_PIX);
    assign rom_addr_d = oob ? scene_base
                            : scene_base + (ROM_AW'(iy) << XW) + ROM_AW'(ix);

    // ---------------- fade FSM ----------------
    assign sel_clamped = (int'(scene_sel) >= NUM_SCENES) ? SW'(NUM_SCENES-1) : scene_sel;

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        active_d  = active_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                // frame_start is ignored here, so a coincident request takes
                // its first level step on the following frame_start.
                if (scene_req) begin
                    state_d   = FADE_OUT;
                    pending_d = sel_clamped;
                end
            end
            FADE_OUT: begin
                if (frame_start) begin
                    level_d = level_q - LEVEL_W'(FADE_STEP);
                    // Scene swaps only at a frame boundary while fully dark.
                    if (level_d == '0) begin
                        active_d = pending_q;
                        state_d  = FADE_IN;
                    end
                end
            end
            FADE_IN: begin
                if (frame_start) begin
                    level_d = level_q + LEVEL_W'(FADE_STEP);
                    if (level_d == LEVEL_W'(LEVEL_MAX)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- stage 3: palette + fade ----------------
    scene_palette_lut u_pal (
        .idx_i (rom_q),
        .rgb_o (pal_rgb)
    );

    always_comb begin
        red_d   = 4'd0;
        green_d = 4'd0;
        blue_d  = 4'd0;
        if (vld_pipe_q[1] && !oob_pipe_q[1]) begin
            red_d   = fade_ch(pal_rgb[11:8], level_q);
            green_d = fade_ch(pal_rgb[7:4],  level_q);
            blue_d  = fade_ch(pal_rgb[3:0],  level_q);
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            level_q      <= LEVEL_W'(LEVEL_MAX);
            active_q     <= '0;
            pending_q    <= '0;
            scroll_lat_q <= '0;
            rom_addr_q   <= '0;
            vld_pipe_q   <= '0;
            oob_pipe_q   <= '0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            if (frame_start) scroll_lat_q <= scroll_x;
            rom_addr_q <= rom_addr_d;
            vld_pipe_q <= {vld_pipe_q[0], blank};
            oob_pipe_q <= {oob_pipe_q[0], oob};
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign busy     = (state_q != IDLE);
    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;

endmodule

// File: tb/tb_scene_renderer.sv
// Scoreboard bench for scene_renderer: a reference model computes the ROM
// address, busy flag and RGB for every driven cycle and queues them with the
// cycle they are due; a negedge monitor pops and compares.
module tb_scene_renderer;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  draw_x, draw_y;
    logic        blank, frame_start, scene_req;
    logic [7:0]  scroll_x;
    logic [1:0]  scene_sel;
    logic [17:0] rom_addr;
    logic [3:0]  rom_q;
    logic        busy;
    logic [3:0]  red, green, blue;

    always #5 vga_clk = ~vga_clk;

    scene_renderer dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .blank       (blank),
        .frame_start (frame_start),
        .scroll_x    (scroll_x),
        .scene_sel   (scene_sel),
        .scene_req   (scene_req),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .busy        (busy),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    // External synchronous ROM with a position-dependent pattern
    function automatic int rom_fn(input int a);
        return (a & 15) ^ ((a >> 6) & 15) ^ ((a >> 14) & 15);
    endfunction

    always @(posedge vga_clk) rom_q <= 4'(rom_fn(int'(rom_addr)));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct { int due; int val; } exp_t;
    exp_t aq[$];
    exp_t cq[$];
    exp_t bq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge vga_clk) begin : monitor
        exp_t e;
        while (aq.size() > 0 && aq[0].due == cyc) begin
            e = aq.pop_front();
            chk("addr", 32'(rom_addr), e.val);
        end
        while (bq.size() > 0 && bq[0].due == cyc) begin
            e = bq.pop_front();
            chk("busy", 32'(busy), e.val);
        end
        while (cq.size() > 0 && cq[0].due == cyc) begin
            e = cq.pop_front();
            chk("rgb", {20'd0, red, green, blue}, e.val);
        end
    end

    // Reference model state
    int m_state, m_level, m_active, m_pending, m_scroll;
    int cur_scroll = 0;

    function automatic int sc(input int c);
        return (c * m_level) / 16;
    endfunction

    task automatic drive(input int x, input int y, input bit bl, input bit fs,
                         input int scr, input int sel, input bit req);
        int ix, iy, a, idx, rgb;
        bit oob;
        @(negedge vga_clk);
        #1;
        draw_x      = 10'(x);
        draw_y      = 10'(y);
        blank       = bl;
        frame_start = fs;
        scroll_x    = 8'(scr);
        scene_sel   = 2'(sel);
        scene_req   = req;
        ix  = ((x >> 1) + m_scroll) % 256;
        iy  = y >> 1;
        oob = (iy >= 240);
        a   = m_active * 61440 + (oob ? 0 : iy * 256 + ix);
        aq.push_back('{cyc + 1, a});
        if (!bl || oob) rgb = 0;
        else begin
            idx = rom_fn(a);
            rgb = (sc(idx) << 8) | (sc(15 - idx) << 4) | sc(idx ^ 5);
        end
        cq.push_back('{cyc + 3, rgb});
        if (fs) m_scroll = scr & 255;
        case (m_state)
            0: if (req) begin m_state = 1; m_pending = ((sel & 3) >= 4) ? 3 : (sel & 3); end
            1: if (fs) begin
                   m_level -= 2;
                   if (m_level == 0) begin m_active = m_pending; m_state = 2; end
               end
            default: if (fs) begin
                   m_level += 2;
                   if (m_level == 16) m_state = 0;
               end
        endcase
        bq.push_back('{cyc + 1, (m_state != 0) ? 1 : 0});
    endtask

    task automatic px(input int x, input int y);
        drive(x, y, 1'b1, 1'b0, cur_scroll, 0, 1'b0);
    endtask

    // Blank lead-in cycle, then the frame_start cycle (also blank)
    task automatic frame(input int scr, input bit req, input int sel);
        drive(0, 0, 1'b0, 1'b0, cur_scroll, 0, 1'b0);
        cur_scroll = scr;
        drive(0, 0, 1'b0, 1'b1, scr, sel, req);
    endtask

    task automatic row(input int n);
        for (int i = 0; i < n; i++) px($urandom_range(0, 639), $urandom_range(0, 479));
    endtask

    task automatic do_reset();
        @(negedge vga_clk);
        #1;
        reset = 1'b1; blank = 1'b0; frame_start = 1'b0; scene_req = 1'b0;
        draw_x = '0; draw_y = '0; scroll_x = '0; scene_sel = '0;
        aq.delete(); bq.delete(); cq.delete();
        repeat (2) @(negedge vga_clk);
        chk("rst_red",   32'(red),      0);
        chk("rst_green", 32'(green),    0);
        chk("rst_blue",  32'(blue),     0);
        chk("rst_addr",  32'(rom_addr), 0);
        chk("rst_busy",  32'(busy),     0);
        #1;
        reset = 1'b0;
        m_state = 0; m_level = 16; m_active = 0; m_pending = 0; m_scroll = 0;
        cur_scroll = 0;
    endtask

    initial begin
        reset = 1'b1; blank = 1'b0; frame_start = 1'b0; scene_req = 1'b0;
        draw_x = '0; draw_y = '0; scroll_x = '0; scene_sel = '0;
        do_reset();

        // Latency / base address: (10,4) scroll 0 -> 517 with scene 0 is 5+2*256
        px(10, 4);
        for (int x = 0; x < 40; x += 3) px(x, 6);

        // Horizontal wrap at scroll 250, seam crossed around x = 12
        frame(250, 1'b0, 0);
        for (int x = 0; x <= 30; x++) px(x, 8);
        // Mid-frame scroll change must not move the address
        cur_scroll = 100;
        for (int x = 18; x <= 24; x++) px(x, 8);
        frame(100, 1'b0, 0);
        for (int x = 18; x <= 24; x++) px(x, 8);

        // Out-of-image rows and blanking
        px(0, 478); px(5, 479); px(5, 480); px(100, 600); px(639, 1023);
        drive(7, 8, 1'b0, 1'b0, cur_scroll, 0, 1'b0);
        row(20);

        // Fade to scene 2, request coincident with frame_start
        frame(0, 1'b1, 2);
        row(6);
        for (int f = 1; f <= 16; f++) begin
            frame(f * 7, 1'b0, 0);
            row(6);
            if (f == 10) begin
                drive(30, 30, 1'b1, 1'b0, cur_scroll, 1, 1'b1);
                row(3);
            end
        end
        frame(0, 1'b0, 0);
        row(8);

        // Fade to scene 3, abort by reset at level 6
        drive(12, 40, 1'b1, 1'b0, cur_scroll, 3, 1'b1);
        row(3);
        for (int f = 1; f <= 5; f++) begin
            frame(f * 3, 1'b0, 0);
            row(4);
        end
        do_reset();
        px(10, 4);
        row(10);

        // Drain the scoreboard
        repeat (4) drive(0, 0, 1'b0, 1'b0, cur_scroll, 0, 1'b0);
        repeat (5) @(negedge vga_clk);
        chk("drain", 32'(aq.size() + bq.size() + cq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
